// File: rtl/timer_mmss_countdown.sv
// MM:SS BCD countdown timer with tick prescaler, run/pause/done control and terminal-count pulse.
// One register stage: outputs update on the edge after load/start/stop/tick; zero is combinational from the digits.
module timer_mmss_countdown #(
  parameter int MIN_DIGITS = 2,
  parameter int TICK_DIV   = 1
) (
  input  logic                        clk,
  input  logic                        clear,
  input  logic                        load,
  input  logic                        start,
  input  logic                        stop,
  input  logic [4*(MIN_DIGITS+2)-1:0] bcd_digits_input,
  output logic [4*(MIN_DIGITS+2)-1:0] bcd_digits_output,
  output logic                        zero,
  output logic                        tc,
  output logic                        running
);

  localparam int NDIG = MIN_DIGITS + 2;
  localparam int W    = 4 * NDIG;
  localparam int PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    digits, digits_nxt, dec_val;
  logic [PW-1:0]   pre, pre_nxt;
  logic            tc_nxt;

  // Digit 1 is the seconds-tens digit (mod 6); every other digit is mod 10.
  function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [3:0]   d;
    r = '0;
    for (int i = 0; i < NDIG; i++) begin
      d = v[4*i +: 4];
      if (i == 1) r[4*i +: 4] = (d > 4'd5) ? 4'd5 : d;
      else        r[4*i +: 4] = (d > 4'd9) ? 4'd9 : d;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] decrement(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [3:0]   d;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          r[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
        end else begin
          r[4*i +: 4] = d - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign dec_val = decrement(digits);

  always_comb begin
    state_nxt  = state;
    digits_nxt = digits;
    pre_nxt    = pre;
    tc_nxt     = 1'b0;
    if (load) begin
      digits_nxt = sanitize(bcd_digits_input);
      pre_nxt    = '0;
      state_nxt  = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!stop && start && !zero) begin
            state_nxt = RUNNING;
            pre_nxt   = '0;
          end
        end
        RUNNING: begin
          if (stop) begin
            state_nxt = PAUSED;
          end else if (pre == PRE_LAST) begin
            pre_nxt    = '0;
            digits_nxt = dec_val;
            if (dec_val == '0) begin
              state_nxt = DONE;
              tc_nxt    = 1'b1;
            end
          end else begin
            pre_nxt = pre + 1'b1;
          end
        end
        PAUSED: begin
          // Second stop while paused cancels the cook time.
          if (stop) begin
            digits_nxt = '0;
            pre_nxt    = '0;
            state_nxt  = IDLE;
          end else if (start) begin
            state_nxt = RUNNING;
          end
        end
        DONE: begin
          if (stop) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state  <= IDLE;
      digits <= '0;
      pre    <= '0;
      tc     <= 1'b0;
    end else begin
      state  <= state_nxt;
      digits <= digits_nxt;
      pre    <= pre_nxt;
      tc     <= tc_nxt;
    end
  end

  assign bcd_digits_output = digits;
  assign zero              = (digits == '0);
  assign running           = (state == RUNNING);

endmodule

// File: doc/timer_mmss_countdown.md
Name: timer_mmss_countdown

Overview:
Parametrised multi-digit BCD countdown timer for the microwave cook-time path. It chains one mod-10 seconds-units digit, one mod-6 seconds-tens digit and MIN_DIGITS mod-10 minute digits into a single MM:SS down-counter. It adds a tick prescaler, a run/pause/done state machine, load-value sanitising and a terminal-count pulse. It feeds the display and the magnetron-enable logic.

Parameters:
MIN_DIGITS, 2, number of BCD minute digits (1..3)
TICK_DIV, 1, clk cycles per one-second decrement (>=1; 1 means decrement every cycle)

Ports:
clk  input  1  system clock, rising edge
clear  input  1  asynchronous active-high reset
load  input  1  synchronous load of bcd_digits_input
start  input  1  start or resume countdown
stop  input  1  pause when running; cancel when paused or done
bcd_digits_input  input  4*(MIN_DIGITS+2)  load value, packed as {min MSD..min LSD, sec tens, sec units}
bcd_digits_output  output  4*(MIN_DIGITS+2)  current value, same packing, registered
zero  output  1  high when every digit is 0
tc  output  1  one-cycle pulse when the count reaches 00:00 from a running decrement
running  output  1  high in RUNNING

Behaviour:
- Reset (clear=1, async): all digits 0, prescaler 0, state IDLE, tc=0, running=0, zero=1. The reset holds while clear is high.
- States: IDLE, RUNNING, PAUSED, DONE.
- Priority per edge: clear > load > stop > start.
- load (any state): registers the sanitised input, prescaler=0, state goes to IDLE. A load on the same edge as a decrement wins; no decrement occurs.
- Sanitising: seconds-tens value >5 is stored as 5. Any other digit >9 is stored as 9.
- IDLE: start with a nonzero value goes to RUNNING and prescaler=0. start with value 0 stays IDLE; no tc. stop has no effect.
- RUNNING: prescaler counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps and the value decrements by one second.
  - First decrement occurs TICK_DIV edges after the start edge.
  - stop goes to PAUSED; the prescaler value is held, not cleared.
- Decrement and borrow:
  - Seconds-units 0 wraps to 9 and borrows.
  - Seconds-tens 0 wraps to 5 and borrows.
  - Each minute digit 0 wraps to 9 and borrows into the next minute digit.
  - No borrow out of the minute MSD is possible, since the count never decrements from 0.
- Reaching zero: a decrement that produces all-zero asserts tc for exactly that following cycle (registered) and moves to DONE. running drops on the same edge.
- PAUSED: value and prescaler frozen. start goes to RUNNING and resumes the prescaler from its held value. stop clears all digits to 0 and goes to IDLE (cancel); no tc.
- DONE: value 0. stop or load goes to IDLE; load also applies its value. start is ignored.
- zero is combinational from the digit registers. running = (state==RUNNING).
- tc never asserts on load, cancel, clear, or start-at-zero.
- Prescaler width is max(1, clog2(TICK_DIV)).

Test Plan:
1. MIN_DIGITS=2, TICK_DIV=1: load 16'h0100, then start → next edge 00:59, running=1. Count reaches 00:00 at the 60th edge after start; tc high exactly one cycle; state DONE; running=0; zero=1.
2. Load 16'h097C → output 16'h0959 (tens 7→5, units C→9). Start; after 1 tick the output is 16'h0958. Borrow check: load 16'h1000, one tick → 16'h0959.
3. Load 16'h0010, start, assert stop after 3 ticks → holds 16'h0007 for 20 cycles, running=0. start → 16'h0006 on the next tick. stop, then stop again → 16'h0000, IDLE, tc never pulsed.
4. Load 0 then start → stays IDLE, running=0, tc=0. Load 16'h0005, start, then load 16'h0300 at the 2nd tick → output 16'h0300, IDLE, no decrement that cycle.
5. Load 16'h0030, start, assert clear asynchronously between edges → outputs zero immediately, before the next clk edge. After clear deasserts, start is ignored because the value is 0.
6. TICK_DIV=4, MIN_DIGITS=3: load 24'h001000, start → first change at the 4th edge to 24'h000959, then changes every 4 edges. Pause at prescaler=2, resume → next decrement after exactly 2 more edges.
